// File: rtl/game_sequencer_if.sv
// Signal bundle between the game sequencer and the surrounding game blocks
// (debouncer, collision checker, tube and bird renderers).
interface game_sequencer_if #(
    parameter int unsigned SCORE_W = 10
);
    logic               btn_flap;
    logic               collision;
    logic [10:0]        tube_x [2:0];
    logic               game_rst;
    logic               move_tick;
    logic [3:0]         tube_speed;
    logic               flap_pulse;
    logic [1:0]         state;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] high_score;

    modport master (
        output btn_flap, collision, tube_x,
        input  game_rst, move_tick, tube_speed, flap_pulse, state, score, high_score
    );

    modport slave (
        input  btn_flap, collision, tube_x,
        output game_rst, move_tick, tube_speed, flap_pulse, state, score, high_score
    );
endinterface

// File: rtl/game_sequencer.sv
// Game controller: idle/run/dying/over state machine, movement-step strobe,
// tube scoring with speed-up, and high-score tracking.
module game_sequencer #(
    parameter int unsigned TICK_MAX      = 1_200_000,
    parameter int unsigned BIRD_X        = 200,
    parameter int unsigned TUBE_WIDTH    = 120,
    parameter int unsigned SCORE_W       = 10,
    parameter int unsigned BASE_SPEED    = 2,
    parameter int unsigned MAX_SPEED     = 6,
    parameter int unsigned SPEEDUP_EVERY = 5,
    parameter int unsigned DEATH_STEPS   = 60
) (
    input  logic             clk,
    input  logic             rst,
    game_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DYING = 2'd2,
        S_OVER  = 2'd3
    } state_e;

    localparam int unsigned TICK_W  = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam int unsigned DEATH_W = $clog2(DEATH_STEPS + 1);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_MAX - 1);
    localparam logic [DEATH_W-1:0] DEATH_LAST = DEATH_W'(DEATH_STEPS - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    state_e               state_q, state_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SCORE_W-1:0]   high_q, high_d;
    logic [3:0]           speed_q, speed_d;
    logic                 game_rst_q, game_rst_d;
    logic                 move_tick_q, move_tick_d;
    logic                 flap_q, flap_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [DEATH_W-1:0]   death_q, death_d;
    logic [2:0]           passed_q, passed_d;
    logic                 btn_prev_q;

    logic                 flap_edge;
    logic                 tick_wrap;
    logic [TICK_W-1:0]    tick_next;

    logic [1:0]           pts;
    logic [2:0]           passed_scored;
    logic [11:0]          right_edge;
    logic [SCORE_W:0]     score_sum;
    logic [SCORE_W-1:0]   score_new;
    logic [3:0]           speed_new;

    assign flap_edge = bus.btn_flap & ~btn_prev_q;
    assign tick_wrap = (tick_q == TICK_LAST);
    assign tick_next = tick_wrap ? '0 : tick_q + 1'b1;

    // Per-step scoring: tubes whose right edge is left of the bird score once,
    // and re-arm when they reappear to the right of the bird.
    always_comb begin
        pts           = '0;
        passed_scored = passed_q;
        right_edge    = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            right_edge = {1'b0, bus.tube_x[i]} + 12'(TUBE_WIDTH);
            if ((right_edge < 12'(BIRD_X)) && !passed_q[i]) begin
                passed_scored[i] = 1'b1;
                pts              = pts + 2'd1;
            end else if (bus.tube_x[i] > 11'(BIRD_X)) begin
                passed_scored[i] = 1'b0;
            end
        end
        score_sum = {1'b0, score_q} + (SCORE_W+1)'(pts);
        score_new = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
        speed_new = speed_q;
        if (((32'(score_q) / SPEEDUP_EVERY) != (32'(score_new) / SPEEDUP_EVERY)) &&
            (speed_q < 4'(MAX_SPEED))) begin
            speed_new = speed_q + 4'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        high_d      = high_q;
        speed_d     = speed_q;
        game_rst_d  = 1'b0;
        move_tick_d = 1'b0;
        flap_d      = 1'b0;
        tick_d      = tick_q;
        death_d     = death_q;
        passed_d    = passed_q;

        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                if (flap_edge) begin
                    game_rst_d = 1'b1;
                    score_d    = '0;
                    speed_d    = 4'(BASE_SPEED);
                    passed_d   = '0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (move_tick_q) begin
                    score_d  = score_new;
                    speed_d  = speed_new;
                    passed_d = passed_scored;
                end
                // Collision wins over both the flap and a due step strobe.
                if (bus.collision) begin
                    state_d = S_DYING;
                    tick_d  = '0;
                    death_d = '0;
                end else begin
                    tick_d      = tick_next;
                    move_tick_d = tick_wrap;
                    flap_d      = flap_edge;
                end
            end
            S_DYING: begin
                tick_d = tick_next;
                if (tick_wrap) begin
                    if (death_q == DEATH_LAST) begin
                        state_d = S_OVER;
                        tick_d  = '0;
                        high_d  = (score_q > high_q) ? score_q : high_q;
                    end else begin
                        death_d = death_q + 1'b1;
                    end
                end
            end
            S_OVER: begin
                tick_d = '0;
                if (flap_edge) begin
                    game_rst_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            score_q     <= '0;
            high_q      <= '0;
            speed_q     <= 4'(BASE_SPEED);
            game_rst_q  <= 1'b0;
            move_tick_q <= 1'b0;
            flap_q      <= 1'b0;
            tick_q      <= '0;
            death_q     <= '0;
            passed_q    <= '0;
            btn_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            high_q      <= high_d;
            speed_q     <= speed_d;
            game_rst_q  <= game_rst_d;
            move_tick_q <= move_tick_d;
            flap_q      <= flap_d;
            tick_q      <= tick_d;
            death_q     <= death_d;
            passed_q    <= passed_d;
            btn_prev_q  <= bus.btn_flap;
        end
    end

    assign bus.game_rst   = game_rst_q;
    assign bus.move_tick  = move_tick_q;
    assign bus.tube_speed = speed_q;
    assign bus.flap_pulse = flap_q;
    assign bus.state      = state_q;
    assign bus.score      = score_q;
    assign bus.high_score = high_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a 4-cycle movement step and a
// 3-step death animation.
module tb_game_sequencer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    game_sequencer_if #(.SCORE_W(10)) bus ();

    game_sequencer #(
        .TICK_MAX      (4),
        .BIRD_X        (200),
        .TUBE_WIDTH    (120),
        .SCORE_W       (10),
        .BASE_SPEED    (2),
        .MAX_SPEED     (6),
        .SPEEDUP_EVERY (5),
        .DEATH_STEPS   (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_tubes(input logic [10:0] a, input logic [10:0] b, input logic [10:0] c);
        bus.tube_x[0] = a;
        bus.tube_x[1] = b;
        bus.tube_x[2] = c;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"},     32'(bus.state),      32'd0);
        chk({tag, "_score"},     32'(bus.score),      32'd0);
        chk({tag, "_high"},      32'(bus.high_score), 32'd0);
        chk({tag, "_speed"},     32'(bus.tube_speed), 32'd2);
        chk({tag, "_game_rst"},  32'(bus.game_rst),   32'd0);
        chk({tag, "_move_tick"}, 32'(bus.move_tick),  32'd0);
        chk({tag, "_flap"},      32'(bus.flap_pulse), 32'd0);
    endtask

    task automatic start_game();
        bus.btn_flap = 1'b1;
        cyc(1);
        chk("start_game_rst", 32'(bus.game_rst), 32'd1);
        chk("start_state",    32'(bus.state),    32'd1);
        bus.btn_flap = 1'b0;
        cyc(1);
        chk("start_game_rst_end", 32'(bus.game_rst), 32'd0);
    endtask

    // Present tube positions, wait for the next step strobe, then land on the
    // cycle where the score for that step is visible.
    task automatic score_step(input logic [10:0] a, input logic [10:0] b, input logic [10:0] c);
        bit found;
        set_tubes(a, b, c);
        found = 1'b0;
        for (int n = 0; n < 8 && !found; n++) begin
            cyc(1);
            if (bus.move_tick === 1'b1) found = 1'b1;
        end
        chk("step_sync", 32'(found), 32'd1);
        cyc(1);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.btn_flap = 1'b0;
        bus.collision = 1'b0;
        set_tubes(11'd900, 11'd900, 11'd900);
        cyc(3);
        chk_reset_vals("reset");
        rst = 1'b0;
        cyc(2);
        chk("idle_state", 32'(bus.state),     32'd0);
        chk("idle_tick",  32'(bus.move_tick), 32'd0);

        // Game 1: start, step cadence, flap, scoring, speed-up
        start_game();
        cyc(2);
        chk("tick_gap",     32'(bus.move_tick),  32'd0);
        cyc(1);
        chk("tick_first",   32'(bus.move_tick),  32'd1);
        chk("speed_base",   32'(bus.tube_speed), 32'd2);
        cyc(1);
        chk("tick_one_cyc", 32'(bus.move_tick),  32'd0);
        cyc(3);
        chk("tick_second",  32'(bus.move_tick),  32'd1);

        bus.btn_flap = 1'b1;
        cyc(1);
        chk("flap_pulse",   32'(bus.flap_pulse), 32'd1);
        cyc(1);
        chk("flap_held",    32'(bus.flap_pulse), 32'd0);
        bus.btn_flap = 1'b0;

        score_step(11'd82, 11'd900, 11'd900);
        chk("score_at_82",   32'(bus.score), 32'd0);
        score_step(11'd78, 11'd900, 11'd900);
        chk("score_at_78",   32'(bus.score), 32'd1);
        score_step(11'd78, 11'd900, 11'd900);
        chk("score_hold_78", 32'(bus.score), 32'd1);
        score_step(11'd900, 11'd900, 11'd900);
        score_step(11'd78, 11'd900, 11'd900);
        chk("score_rearm",   32'(bus.score), 32'd2);
        score_step(11'd900, 11'd900, 11'd900);
        score_step(11'd78, 11'd900, 11'd900);
        score_step(11'd900, 11'd900, 11'd900);
        score_step(11'd78, 11'd900, 11'd900);
        chk("score_4",       32'(bus.score),      32'd4);
        chk("speed_at_4",    32'(bus.tube_speed), 32'd2);
        score_step(11'd900, 11'd78, 11'd78);
        chk("score_double",  32'(bus.score),      32'd6);
        chk("speed_double",  32'(bus.tube_speed), 32'd3);
        for (int k = 0; k < 6; k++) begin
            score_step(11'd900, 11'd900, 11'd900);
            score_step(11'd78, 11'd78, 11'd78);
        end
        chk("score_24",      32'(bus.score),      32'd24);
        chk("speed_at_24",   32'(bus.tube_speed), 32'd6);
        score_step(11'd900, 11'd900, 11'd900);
        score_step(11'd78, 11'd900, 11'd900);
        chk("score_25",      32'(bus.score),      32'd25);
        chk("speed_cap",     32'(bus.tube_speed), 32'd6);

        // Collision + flap edge on the cycle a step strobe is due
        cyc(2);
        bus.collision = 1'b1;
        bus.btn_flap  = 1'b1;
        cyc(1);
        chk("coll_state",     32'(bus.state),      32'd2);
        chk("coll_no_tick",   32'(bus.move_tick),  32'd0);
        chk("coll_no_flap",   32'(bus.flap_pulse), 32'd0);
        bus.btn_flap = 1'b0;
        cyc(11);
        chk("dying_hold",     32'(bus.state),      32'd2);
        bus.collision = 1'b0;
        cyc(1);
        chk("over_state",     32'(bus.state),      32'd3);
        chk("over_high_25",   32'(bus.high_score), 32'd25);

        bus.btn_flap = 1'b1;
        cyc(1);
        chk("over_exit_state", 32'(bus.state),    32'd0);
        chk("over_exit_rst",   32'(bus.game_rst), 32'd1);
        chk("over_exit_score", 32'(bus.score),    32'd25);
        cyc(2);
        chk("held_no_restart", 32'(bus.state),    32'd0);
        bus.btn_flap = 1'b0;
        set_tubes(11'd900, 11'd900, 11'd900);
        cyc(1);

        // Game 2: reset in the middle of DYING
        start_game();
        bus.collision = 1'b1;
        cyc(1);
        chk("g2_dying", 32'(bus.state), 32'd2);
        bus.collision = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk_reset_vals("mid_dying_rst");
        cyc(1);

        // Game 3: finish with score 7
        start_game();
        chk("g3_score_clr", 32'(bus.score), 32'd0);
        score_step(11'd78, 11'd78, 11'd78);
        score_step(11'd900, 11'd900, 11'd900);
        score_step(11'd78, 11'd78, 11'd78);
        score_step(11'd900, 11'd900, 11'd900);
        score_step(11'd78, 11'd900, 11'd900);
        chk("g3_score", 32'(bus.score),      32'd7);
        chk("g3_speed", 32'(bus.tube_speed), 32'd3);
        bus.collision = 1'b1;
        cyc(1);
        bus.collision = 1'b0;
        cyc(12);
        chk("g3_over",  32'(bus.state),      32'd3);
        chk("g3_high",  32'(bus.high_score), 32'd7);
        bus.btn_flap = 1'b1;
        cyc(1);
        chk("g3_idle",  32'(bus.state), 32'd0);
        bus.btn_flap = 1'b0;
        set_tubes(11'd900, 11'd900, 11'd900);
        cyc(1);

        // Game 4: lower score keeps the high score
        start_game();
        chk("g4_score_clr", 32'(bus.score),      32'd0);
        chk("g4_speed_clr", 32'(bus.tube_speed), 32'd2);
        score_step(11'd78, 11'd78, 11'd78);
        chk("g4_score", 32'(bus.score), 32'd3);
        bus.collision = 1'b1;
        cyc(1);
        bus.collision = 1'b0;
        cyc(12);
        chk("g4_over",  32'(bus.state),      32'd3);
        chk("g4_high",  32'(bus.high_score), 32'd7);
        bus.btn_flap = 1'b1;
        cyc(1);
        chk("g4_idle",       32'(bus.state),    32'd0);
        chk("g4_game_rst",   32'(bus.game_rst), 32'd1);
        chk("g4_score_kept", 32'(bus.score),    32'd3);
        bus.btn_flap = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game controller that sequences the tube-scrolling datapath.
- Owns the game state machine (idle / run / dying / over). Issues the game_rst pulse and per-step move strobe to the tube block.
- Scores tubes passed by the bird and raises tube speed with score. Tracks the high score.
- Sits between the input debouncer, the collision checker and the tube/bird renderers.

Parameters:
- TICK_MAX, 1_200_000, clk cycles per movement step.
- BIRD_X, 200, fixed bird x-coordinate in pixels.
- TUBE_WIDTH, 120, tube width in pixels.
- SCORE_W, 10, score / high_score width.
- BASE_SPEED, 2, tube_speed value at game start.
- MAX_SPEED, 6, tube_speed ceiling.
- SPEEDUP_EVERY, 5, points per speed increment.
- DEATH_STEPS, 60, movement steps spent in DYING before OVER.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- btn_flap  in  1  debounced flap button, level
- collision  in  1  bird/tube or bird/floor overlap, level, sampled every cycle
- tube_x  in  11 x3 (unpacked [2:0])  current tube left edges from tube block
- game_rst  out  1  one-cycle pulse that re-initialises tube and bird blocks
- move_tick  out  1  one-cycle strobe per movement step
- tube_speed  out  4  pixels per step for tube block
- flap_pulse  out  1  one-cycle flap command to bird block
- state  out  2  0=IDLE 1=RUN 2=DYING 3=OVER
- score  out  SCORE_W  current score
- high_score  out  SCORE_W  best score since rst

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE; score=0; high_score=0; tube_speed=BASE_SPEED; game_rst=0; move_tick=0; flap_pulse=0; tick counter=0; passed[2:0]=0; btn_prev=0.
- Flap edge detection: flap_edge = btn_flap & ~btn_prev. btn_prev is registered every cycle. All outputs are registered, so any response appears on the cycle after the causing input.
- IDLE:
  - move_tick=0; tick counter held at 0.
  - On flap_edge: game_rst=1 for 1 cycle; score<=0; tube_speed<=BASE_SPEED; passed<=0; go to RUN.
- RUN:
  - Tick counter runs 0..TICK_MAX-1 and wraps to 0. move_tick=1 for exactly one cycle per wrap.
  - flap_edge gives flap_pulse=1 for one cycle.
  - collision=1 moves state to DYING next cycle and clears the tick counter. If collision and flap_edge occur in the same cycle, collision wins and no flap_pulse is issued. A move_tick due in that same cycle is also suppressed.
- Scoring (RUN only, evaluated per tube i on move_tick cycles):
  - Use 12-bit sum r = tube_x[i] + TUBE_WIDTH.
  - If r < BIRD_X and passed[i]=0: set passed[i] and count the point.
  - If tube_x[i] > BIRD_X: clear passed[i]. This re-arms the tube after wrap to the right.
  - Points from several tubes in the same step are summed.
  - score saturates at 2^SCORE_W-1.
- Speed-up:
  - Each time score crosses a multiple of SPEEDUP_EVERY (old/SPEEDUP_EVERY != new/SPEEDUP_EVERY), tube_speed increments by 1, applied together with the score update.
  - tube_speed never exceeds MAX_SPEED.
- DYING:
  - move_tick=0 and flap_pulse=0. Tubes freeze.
  - Tick counter keeps running. After DEATH_STEPS internal wraps, go to OVER.
  - collision is ignored.
- OVER:
  - On entry (same edge as the state change), high_score <= max(high_score, score).
  - On flap_edge: game_rst pulse, then IDLE. score is retained until the next IDLE->RUN transition.
- Button held across a transition: holding btn_flap does not re-trigger. A new rising edge is always required.
- rst in any state forces the reset values on the next edge, including mid-DYING and mid-step.

Test Plan:
- Start, TICK_MAX=4: rst, then btn_flap rising -> 1 cycle later game_rst=1 for one cycle and state=1. Then move_tick pulses every 4 cycles and tube_speed=2.
- Scoring, BIRD_X=200, TUBE_WIDTH=120: drive tube_x[0] 82 -> 78 across a move_tick -> score 0 -> 1. Hold at 78 for further ticks -> score stays 1. Set tube_x[0]=900 -> passed cleared; bring to 78 again -> score=2.
- Double pass + speed: two tubes cross in the same step at score=4, SPEEDUP_EVERY=5 -> score=6 and tube_speed=3. Push to score 25 -> tube_speed capped at 6.
- Collision priority: collision and flap_edge in the same cycle as a move_tick -> no flap_pulse, no move_tick, state=2. After DEATH_STEPS*TICK_MAX cycles -> state=3.
- High score: finish a game with score=7, then a game with score=3 -> high_score=7 after each OVER entry. A flap in OVER -> game_rst pulse, state=0, score still shows 3.
- Reset mid-DYING: assert rst for 1 cycle -> all outputs at reset values next cycle, and high_score=0.
